// File: rtl/tt_pad_pkg.sv
// rtl/tt_pad_pkg.sv - shared pad-ring controller types and constants
package tt_pad_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        RAMP   = 2'd2,
        ON     = 2'd3
    } pad_state_e;

    localparam logic [17:0] DEF_SAFE_CFG = 18'h00000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pad_ring_ctrl_if.sv
// rtl/pad_ring_ctrl_if.sv - project-side and pad-side signal bundle for the pad ring
interface pad_ring_ctrl_if #(
    parameter int NUM_PADS = 4,
    parameter int CFG_W    = 18
);
    logic [NUM_PADS-1:0] prj_pad_out;
    logic [NUM_PADS-1:0] prj_pad_dir;
    logic [CFG_W-1:0]    prj_pad_config;
    logic [NUM_PADS-1:0] prj_pad_in;
    logic [NUM_PADS-1:0] pad_in;
    logic [NUM_PADS-1:0] pad_out;
    logic [NUM_PADS-1:0] pad_dir;
    logic [CFG_W-1:0]    pad_config;

    // Project and physical pads together drive this side
    modport master (
        output prj_pad_out, prj_pad_dir, prj_pad_config, pad_in,
        input  prj_pad_in, pad_out, pad_dir, pad_config
    );

    // The controller sits between them
    modport slave (
        input  prj_pad_out, prj_pad_dir, prj_pad_config, pad_in,
        output prj_pad_in, pad_out, pad_dir, pad_config
    );
endinterface

// File: rtl/pad_in_sync.sv
// rtl/pad_in_sync.sv - two-flop synchroniser for asynchronous pad inputs
module pad_in_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q;

    // Two back-to-back flops; both cleared so the project never sees stale pad data after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/pad_ring_ctrl.sv
// rtl/pad_ring_ctrl.sv - pad-ring controller with safe state, config-first enable and staggered output release
module pad_ring_ctrl
    import tt_pad_pkg::*;
#(
    parameter int               NUM_PADS   = 4,
    parameter int               CFG_W      = 18,
    parameter logic [CFG_W-1:0] SAFE_CFG   = CFG_W'(DEF_SAFE_CFG),
    parameter int               SETTLE_CYC = 4,
    parameter int               STAGGER    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    pad_ring_ctrl_if.slave        pads,
    output logic                  active
);
    localparam int CNT_W = $clog2(max_int(SETTLE_CYC, STAGGER) + 1);

    pad_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_PADS-1:0] mask;
    logic [NUM_PADS-1:0] out_q;
    logic [NUM_PADS-1:0] dir_q;
    logic [CFG_W-1:0]    cfg_q;
    logic [NUM_PADS-1:0] sync_q;

    // Sequencer: OFF -> SETTLE (config only) -> RAMP (one pad per STAGGER) -> ON
    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            state  <= OFF;
            cnt    <= '0;
            mask   <= '0;
            active <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    state <= SETTLE;
                    cnt   <= CNT_W'(SETTLE_CYC - 1);
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= RAMP;
                        mask  <= NUM_PADS'(1);
                        cnt   <= CNT_W'(STAGGER - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RAMP: begin
                    if (cnt == '0) begin
                        if (&mask) begin
                            state  <= ON;
                            active <= 1'b1;
                        end else begin
                            mask <= (mask << 1) | NUM_PADS'(1);
                            cnt  <= CNT_W'(STAGGER - 1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ON: begin
                    active <= 1'b1;
                end
                default: begin
                    state  <= OFF;
                    mask   <= '0;
                    active <= 1'b0;
                end
            endcase
        end
    end

    // Project data/config capture; loads the safe values on the same edge the sequencer drops to OFF,
    // so config is already live on the first SETTLE cycle
    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            out_q <= '0;
            dir_q <= '0;
            cfg_q <= SAFE_CFG;
        end else begin
            out_q <= pads.prj_pad_out;
            dir_q <= pads.prj_pad_dir;
            cfg_q <= pads.prj_pad_config;
        end
    end

    pad_in_sync #(
        .WIDTH (NUM_PADS)
    ) u_pad_in_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pads.pad_in),
        .q     (sync_q)
    );

    assign pads.pad_out    = out_q & mask;
    assign pads.pad_dir    = dir_q & mask;
    assign pads.pad_config = cfg_q;
    assign pads.prj_pad_in = sync_q & {NUM_PADS{state != OFF}};

endmodule

// File: tb/tb_pad_ring_ctrl.sv
// tb/tb_pad_ring_ctrl.sv - scoreboard bench for pad_ring_ctrl (default and single-pad builds)
module tb_pad_ring_ctrl;

    logic clk;
    logic rst_n, ena, active;
    logic rst_n1, ena1, active1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    pad_ring_ctrl_if #(.NUM_PADS(4), .CFG_W(18)) pif ();
    pad_ring_ctrl_if #(.NUM_PADS(1), .CFG_W(18)) pif1 ();

    pad_ring_ctrl #(
        .NUM_PADS(4), .CFG_W(18), .SAFE_CFG(18'h00000), .SETTLE_CYC(4), .STAGGER(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pads(pif.slave), .active(active)
    );

    pad_ring_ctrl #(
        .NUM_PADS(1), .CFG_W(18), .SAFE_CFG(18'h0F0F0), .SETTLE_CYC(1), .STAGGER(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n1), .ena(ena1), .pads(pif1.slave), .active(active1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sel;
        string       name;
        logic [3:0]  dir;
        logic [3:0]  out;
        logic [17:0] cfg;
        logic        act;
        logic [3:0]  pin;
    } exp_t;

    exp_t q[$];
    exp_t e;

    // Expected pad_dir / pad_out after edge Ek with prj_pad_dir=F, prj_pad_out=A
    localparam logic [3:0] DIR_TAB [13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
    localparam logic [3:0] OUT_TAB [13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'hA, 4'hA, 4'hA};

    task automatic push(input int sel, input string name, input logic [3:0] dir, input logic [3:0] out,
                        input logic [17:0] cfg, input logic act, input logic [3:0] pin);
        exp_t x;
        x.cyc = cyc; x.sel = sel; x.name = name;
        x.dir = dir; x.out = out; x.cfg = cfg; x.act = act; x.pin = pin;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_seq(input string tag, input int n, input logic [17:0] cfg, input logic [3:0] pin);
        for (int k = 0; k < n; k++) begin
            step(1);
            push(0, $sformatf("%s_e%0d", tag, k), DIR_TAB[k], OUT_TAB[k], cfg, (k >= 12), pin);
        end
    endtask

    // Monitor: compare every expectation due at this cycle against the sampled outputs
    always @(negedge clk) begin
        logic [30:0] got, want;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d not compared (now %0d)", e.name, e.cyc, cyc);
            end else begin
                if (e.sel == 0)
                    got = {pif.pad_dir, pif.pad_out, pif.pad_config, active, pif.prj_pad_in};
                else
                    got = {3'b000, pif1.pad_dir, 3'b000, pif1.pad_out, pif1.pad_config, active1,
                           3'b000, pif1.prj_pad_in};
                want = {e.dir, e.out, e.cfg, e.act, e.pin};
                if (got !== want) begin
                    failures++;
                    $display("FAIL %s: got dir=%h out=%h cfg=%h act=%b pin=%h, want dir=%h out=%h cfg=%h act=%b pin=%h",
                             e.name, got[30:27], got[26:23], got[22:5], got[4], got[3:0],
                             e.dir, e.out, e.cfg, e.act, e.pin);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1;
        pif.prj_pad_dir = 4'hF; pif.prj_pad_out = 4'hA; pif.prj_pad_config = 18'h3FFFF; pif.pad_in = 4'h0;
        rst_n1 = 1'b0; ena1 = 1'b0;
        pif1.prj_pad_dir = 1'b1; pif1.prj_pad_out = 1'b1; pif1.prj_pad_config = 18'h15555; pif1.pad_in = 1'b1;

        step(2);
        push(0, "reset", 4'h0, 4'h0, 18'h00000, 1'b0, 4'h0);
        push(1, "reset1", 4'h0, 4'h0, 18'h0F0F0, 1'b0, 4'h0);

        // Release reset with ena held high: sequence starts at the next edge
        rst_n = 1'b1;
        run_seq("ramp", 13, 18'h3FFFF, 4'h0);

        // ON: config and data track with one edge, pad_in through two flops
        pif.pad_in = 4'h5;
        pif.prj_pad_config = 18'h00001;
        step(1);
        push(0, "cfg_a", 4'hF, 4'hA, 18'h00001, 1'b1, 4'h0);
        pif.prj_pad_config = 18'h2AAAA;
        step(1);
        push(0, "cfg_b_pin", 4'hF, 4'hA, 18'h2AAAA, 1'b1, 4'h5);
        pif.prj_pad_out = 4'h5;
        step(1);
        push(0, "out_track", 4'hF, 4'h5, 18'h2AAAA, 1'b1, 4'h5);

        // Disable from ON, then pad_in moves while OFF
        ena = 1'b0;
        step(1);
        push(0, "off_from_on", 4'h0, 4'h0, 18'h00000, 1'b0, 4'h0);
        pif.pad_in = 4'hA;
        for (int i = 0; i < 3; i++) begin
            step(1);
            push(0, $sformatf("off_pin%0d", i), 4'h0, 4'h0, 18'h00000, 1'b0, 4'h0);
        end

        // Re-enable, drop during RAMP with mask=3
        pif.prj_pad_out = 4'hA;
        ena = 1'b1;
        run_seq("ramp2", 7, 18'h2AAAA, 4'hA);
        ena = 1'b0;
        step(1);
        push(0, "off_from_ramp", 4'h0, 4'h0, 18'h00000, 1'b0, 4'h0);

        // ena back high right after the edge that entered OFF: full sequence again
        ena = 1'b1;
        run_seq("ramp3", 13, 18'h2AAAA, 4'hA);

        // Single-pad build, SETTLE_CYC=1, STAGGER=1
        rst_n1 = 1'b1; ena1 = 1'b1;
        step(1);
        push(1, "p1_settle", 4'h0, 4'h0, 18'h15555, 1'b0, 4'h0);
        step(1);
        push(1, "p1_ramp", 4'h1, 4'h1, 18'h15555, 1'b0, 4'h1);
        step(1);
        push(1, "p1_on", 4'h1, 4'h1, 18'h15555, 1'b1, 4'h1);
        rst_n1 = 1'b0; ena1 = 1'b0;
        step(1);
        push(1, "p1_rst_ena_off", 4'h0, 4'h0, 18'h0F0F0, 1'b0, 4'h0);
        step(1);
        push(1, "p1_off_hold", 4'h0, 4'h0, 18'h0F0F0, 1'b0, 4'h0);

        for (int i = 0; i < 10 && q.size() > 0; i++) step(1);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
